// File: rtl/nbit_serial_logic.sv
// nbit_serial_logic: handshaked bitwise AND/OR/XOR/NOR evaluated W bits per cycle, LSB chunk first.
// Optional parity output enabled by defining SERIAL_LOGIC_PARITY_EN.
module nbit_serial_logic #(
    parameter int N = 32,
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [1:0]   op,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] result,
`ifdef SERIAL_LOGIC_PARITY_EN
    output logic         parity,
`endif
    output logic         zero
);
    localparam int K = N / W;
    localparam int CW = (K > 1) ? $clog2(K) : 1;
    localparam logic [CW-1:0] LAST = CW'(K - 1);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic [N-1:0]  a_q, b_q, result_q, result_d;
    logic [1:0]    op_q;
    logic          zero_q;
    logic [W-1:0]  ca, cb, chunk;
    int            idx;
    always_comb begin
        idx = int'(cnt_q) * W;
        ca = a_q[idx +: W];
        cb = b_q[idx +: W];
        chunk = (op_q == 2'b00) ? (ca & cb) :
                (op_q == 2'b01) ? (ca | cb) :
                (op_q == 2'b10) ? (ca ^ cb) : ~(ca | cb);
        result_d = result_q;
        result_d[idx +: W] = chunk;
    end
`ifdef SERIAL_LOGIC_PARITY_EN
    logic parity_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            parity_q <= 1'b0;
        else if (state_q == IDLE && in_valid)
            parity_q <= 1'b0;
        else if (state_q == RUN)
            parity_q <= parity_q ^ (^chunk);
    end
    assign parity = parity_q;
`endif
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= '0;
            result_q <= '0;
            zero_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (in_valid) begin
                    a_q     <= a;
                    b_q     <= b;
                    op_q    <= op;
                    cnt_q   <= '0;
                    state_q <= RUN;
                end
                RUN: begin
                    result_q <= result_d;
                    cnt_q    <= (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
                    if (cnt_q == LAST) begin
                        state_q <= DONE;
                        zero_q  <= (result_d == '0);
                    end
                end
                DONE: if (out_ready) begin
                    state_q <= IDLE;
                    zero_q  <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign result    = result_q;
    assign zero      = zero_q;
endmodule

// File: tb/tb_nbit_serial_logic.sv
// tb_nbit_serial_logic: table, directed and random checks of a W=4 and a W=N instance sharing inputs.
module tb_nbit_serial_logic;
    logic        clk = 1'b0;
    logic        rst_n, in_valid, out_ready;
    logic [1:0]  op;
    logic [31:0] a, b;
    logic        in_ready, out_valid, zero, in_ready1, out_valid1, zero1;
    logic [31:0] result, result1;
`ifdef SERIAL_LOGIC_PARITY_EN
    logic        parity, parity1;
`endif
    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    nbit_serial_logic #(.N(32), .W(4)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .op(op),
        .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready), .result(result),
`ifdef SERIAL_LOGIC_PARITY_EN
        .parity(parity),
`endif
        .zero(zero));

    nbit_serial_logic #(.N(32), .W(32)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1), .op(op),
        .a(a), .b(b), .out_valid(out_valid1), .out_ready(out_ready), .result(result1),
`ifdef SERIAL_LOGIC_PARITY_EN
        .parity(parity1),
`endif
        .zero(zero1));

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a, b, r;
        logic        z;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] ref_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        case (o)
            2'b00:   return x & y;
            2'b01:   return x | y;
            2'b10:   return x ^ y;
            default: return ~(x | y);
        endcase
    endfunction

    // Starts and ends on a negedge with both instances idle.
    task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                          input logic [31:0] er, input logic ez, input bit scr, input int hold);
        int cyc, cyc1;
        chk("in_ready_idle", 32'(in_ready), 32'd1);
        in_valid = 1'b1; op = o; a = x; b = y;
        @(negedge clk);
        in_valid = 1'b0;
        cyc = 0;
        cyc1 = -1;
        chk("in_ready_run", 32'(in_ready), 32'd0);
        while (!out_valid && cyc < 50) begin
            if (out_valid1 && cyc1 < 0) cyc1 = cyc;
            if (in_ready || out_valid) chk("ready_valid_excl", 32'(in_ready & out_valid), 32'd0);
            if (scr) begin
                a = $urandom; b = $urandom; op = 2'($urandom); in_valid = 1'($urandom);
            end
            @(negedge clk);
            cyc++;
        end
        in_valid = 1'b0;
        chk("latency_w4", 32'(cyc), 32'd8);
        chk("latency_wn", 32'(cyc1), 32'd1);
        chk("result_w4", result, er);
        chk("zero_w4", 32'(zero), 32'(ez));
        chk("result_wn", result1, er);
        chk("zero_wn", 32'(zero1), 32'(ez));
        chk("in_ready_done", 32'(in_ready), 32'd0);
`ifdef SERIAL_LOGIC_PARITY_EN
        chk("parity_w4", 32'(parity), 32'(^er));
        chk("parity_wn", 32'(parity1), 32'(^er));
`endif
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'(i & 1);
            a = $urandom; b = $urandom;
            @(negedge clk);
            chk("hold_result", result, er);
            chk("hold_zero", 32'(zero), 32'(ez));
            chk("hold_valid", 32'(out_valid), 32'd1);
            chk("hold_in_ready", 32'(in_ready), 32'd0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("idle_in_ready", 32'(in_ready), 32'd1);
        chk("idle_out_valid", 32'(out_valid), 32'd0);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vec_t tbl[8];
        logic [1:0]  ro;
        logic [31:0] ra, rb, rr;
        tbl[0] = '{2'b00, 32'hA5A5_1234, 32'h0FF0_FFFF, 32'h05A0_1234, 1'b0};
        tbl[1] = '{2'b01, 32'hA5A5_1234, 32'h0FF0_FFFF, 32'hAFF5_FFFF, 1'b0};
        tbl[2] = '{2'b10, 32'hA5A5_1234, 32'h0FF0_FFFF, 32'hAA55_EDCB, 1'b0};
        tbl[3] = '{2'b11, 32'hA5A5_1234, 32'h0FF0_FFFF, 32'h500A_0000, 1'b0};
        tbl[4] = '{2'b00, 32'hF0F0_F0F0, 32'h0F0F_0F0F, 32'h0000_0000, 1'b1};
        tbl[5] = '{2'b10, 32'h0000_0001, 32'h0000_0001, 32'h0000_0000, 1'b1};
        tbl[6] = '{2'b01, 32'h0000_0000, 32'h8000_0000, 32'h8000_0000, 1'b0};
        tbl[7] = '{2'b01, 32'h0000_0007, 32'h0000_0000, 32'h0000_0007, 1'b0};
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; op = '0; a = '0; b = '0;
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_result", result, 32'd0);
        chk("rst_zero", 32'(zero), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 8; i++)
            run_op(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].r, tbl[i].z, 1'b0, 0);
        // Reset three cycles into a run.
        in_valid = 1'b1; op = 2'b00; a = 32'hFFFF_FFFF; b = 32'h0F0F_0F0F;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrun_out_valid", 32'(out_valid), 32'd0);
        chk("midrun_result", result, 32'd0);
        chk("midrun_in_ready", 32'(in_ready), 32'd1);
        chk("midrun_zero", 32'(zero), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_op(2'b00, 32'hFFFF_FFFF, 32'h0F0F_0F0F, 32'h0F0F_0F0F, 1'b0, 1'b0, 0);
        run_op(2'b10, 32'hDEAD_BEEF, 32'h1234_5678, 32'hCC99_E897, 1'b0, 1'b0, 20);
        run_op(2'b11, 32'h0F0F_0000, 32'hF0F0_0000, 32'h0000_FFFF, 1'b0, 1'b1, 0);
        for (int i = 0; i < 30; i++) begin
            ro = 2'($urandom);
            ra = $urandom;
            rb = (i % 5 == 0) ? ((ro == 2'b10) ? ra : ~ra) : $urandom;
            rr = ref_op(ro, ra, rb);
            run_op(ro, ra, rb, rr, rr == 32'd0, i[0], int'($urandom_range(0, 3)));
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
